// File: rtl/seg_scan_if.sv
// Load handshake and display drive bundle for the segment scan controller.
// master = game logic side, slave = scan controller side.
interface seg_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      ld_valid;
   logic                      ld_ready;
   logic [4*NUM_DIGITS-1:0]   ld_value;
   logic                      ld_blank_lz;
   logic [3:0]                nibble;
   logic [NUM_DIGITS-1:0]     digit_en;
   logic                      seg_blank;
   logic                      frame_tick;

   modport master (
      output ld_valid, ld_value, ld_blank_lz,
      input  ld_ready, nibble, digit_en, seg_blank, frame_tick
   );

   modport slave (
      input  ld_valid, ld_value, ld_blank_lz,
      output ld_ready, nibble, digit_en, seg_blank, frame_tick
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-seg scan: double-buffered value applied at frame boundaries, gap+show per digit.
// Outputs registered (1 cycle after state); ld_ready low while the pending buffer holds a value.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000,
   parameter int BLANK_GAP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   seg_scan_if.slave   bus
);
   localparam int VW = 4 * NUM_DIGITS;
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   typedef enum logic {GAP, SHOW} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [VW-1:0]         act_val_q, act_val_d;
   logic                  act_lz_q, act_lz_d;
   logic [VW-1:0]         pend_val_q, pend_val_d;
   logic                  pend_lz_q, pend_lz_d;
   logic                  pend_full_q, pend_full_d;
   logic                  ld_ready_q, ld_ready_d;
   logic [3:0]            nibble_q, nibble_d;
   logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
   logic                  seg_blank_q, seg_blank_d;
   logic                  frame_tick_q, frame_tick_d;

   logic                  last_cnt, boundary, xfer, digit_blank;
   logic [NUM_DIGITS-1:0] zero_above;

   always_comb begin
      last_cnt    = (cnt_q == CW'(PRESCALE - 1));
      boundary    = (state_q == SHOW) && last_cnt && (idx_q == IW'(NUM_DIGITS - 1));
      xfer        = bus.ld_valid && ld_ready_q;

      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = last_cnt ? '0 : cnt_q + CW'(1);

      case (state_q)
         GAP: begin
            if (cnt_q == CW'(BLANK_GAP - 1)) state_d = SHOW;
         end
         SHOW: begin
            if (last_cnt) begin
               state_d = GAP;
               idx_d   = boundary ? '0 : idx_q + IW'(1);
            end
         end
         default: state_d = GAP;
      endcase

      // Boundary copy happens before a same-cycle transfer lands, so a new
      // value offered on the boundary only reaches pending.
      act_val_d   = act_val_q;
      act_lz_d    = act_lz_q;
      pend_val_d  = pend_val_q;
      pend_lz_d   = pend_lz_q;
      pend_full_d = pend_full_q;
      if (boundary && pend_full_q) begin
         act_val_d   = pend_val_q;
         act_lz_d    = pend_lz_q;
         pend_full_d = 1'b0;
      end
      if (xfer) begin
         pend_val_d  = bus.ld_value;
         pend_lz_d   = bus.ld_blank_lz;
         pend_full_d = 1'b1;
      end
      ld_ready_d  = !pend_full_d;

      // zero_above[i]: every active nibble from digit i upward is zero.
      zero_above = '0;
      zero_above[NUM_DIGITS-1] = (act_val_q[VW-1 -: 4] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         zero_above[i] = zero_above[i+1] && (act_val_q[4*i +: 4] == 4'd0);
      end
      digit_blank = act_lz_q && (idx_q != '0) && zero_above[idx_q];

      nibble_d     = act_val_q[4*int'(idx_q) +: 4];
      frame_tick_d = boundary;
      if ((state_q == GAP) || digit_blank) begin
         digit_en_d  = '1;
         seg_blank_d = 1'b1;
      end else begin
         digit_en_d  = ~(NUM_DIGITS'(1) << idx_q);
         seg_blank_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= GAP;
         idx_q        <= '0;
         cnt_q        <= '0;
         act_val_q    <= '0;
         act_lz_q     <= 1'b0;
         pend_val_q   <= '0;
         pend_lz_q    <= 1'b0;
         pend_full_q  <= 1'b0;
         ld_ready_q   <= 1'b1;
         nibble_q     <= 4'd0;
         digit_en_q   <= '1;
         seg_blank_q  <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         act_val_q    <= act_val_d;
         act_lz_q     <= act_lz_d;
         pend_val_q   <= pend_val_d;
         pend_lz_q    <= pend_lz_d;
         pend_full_q  <= pend_full_d;
         ld_ready_q   <= ld_ready_d;
         nibble_q     <= nibble_d;
         digit_en_q   <= digit_en_d;
         seg_blank_q  <= seg_blank_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.ld_ready   = ld_ready_q;
   assign bus.nibble     = nibble_q;
   assign bus.digit_en   = digit_en_q;
   assign bus.seg_blank  = seg_blank_q;
   assign bus.frame_tick = frame_tick_q;
endmodule
